// File: rtl/tank_ctrl_multi.sv
// Multi-pump tank level controller: debounced I/S sensors, round-robin pump
// rotation in HALF, sticky FAULT on inconsistent sensors.
module tank_debounce #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt_inc == CW'(FILTER_CYCLES)) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end
endmodule

module tank_ctrl_multi #(
  parameter int NUM_PUMPS     = 4,
  parameter int FILTER_CYCLES = 4,
  parameter int PTR_W         = $clog2(NUM_PUMPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 I,
  input  logic                 S,
  input  logic [NUM_PUMPS-1:0] pump_en,
  input  logic                 fault_clr,
  output logic [NUM_PUMPS-1:0] B,
  output logic [1:0]           level_state,
  output logic [PTR_W-1:0]     active_pump,
  output logic                 fault,
  output logic                 no_pump
);
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FAULT = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt, sensed;

  logic [1:0]           raw_v;
  logic [1:0]           filt_v;
  logic [PTR_W-1:0]     ptr_adv, ptr_nxt, idx_p;
  logic                 found;
  logic [NUM_PUMPS-1:0] b_nxt;

  // Index 1 = I (lower sensor), index 0 = S (upper sensor)
  assign raw_v = {I, S};

  for (genvar g = 0; g < 2; g++) begin : g_db
    tank_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_v[g]),
      .filt  (filt_v[g])
    );
  end

  always_comb begin
    case (filt_v)
      2'b11:   sensed = FULL;
      2'b10:   sensed = HALF;
      2'b00:   sensed = EMPTY;
      default: sensed = FAULT;
    endcase
  end

  // Next enabled pump strictly after the current pointer; holds if none enabled
  always_comb begin
    ptr_adv = active_pump;
    found   = 1'b0;
    idx_p   = '0;
    for (int i = 1; i <= NUM_PUMPS; i++) begin
      idx_p = PTR_W'((int'(active_pump) + i) % NUM_PUMPS);
      if (!found && pump_en[idx_p]) begin
        ptr_adv = idx_p;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = active_pump;
    b_nxt     = '0;
    if (state == FAULT) begin
      if (fault_clr && sensed != FAULT) state_nxt = sensed;
    end else begin
      state_nxt = sensed;
    end
    if (state_nxt == HALF && (state != HALF || !pump_en[active_pump]))
      ptr_nxt = ptr_adv;
    case (state_nxt)
      EMPTY:   b_nxt = pump_en;
      HALF:    b_nxt = pump_en & (NUM_PUMPS'(1) << ptr_nxt);
      default: b_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FULL;
      B           <= '0;
      active_pump <= PTR_W'(NUM_PUMPS - 1);
      fault       <= 1'b0;
      no_pump     <= 1'b0;
    end else begin
      state       <= state_nxt;
      B           <= b_nxt;
      active_pump <= ptr_nxt;
      fault       <= (state_nxt == FAULT);
      no_pump     <= ~|pump_en;
    end
  end

  assign level_state = state;
endmodule

// File: tb/tb_tank_ctrl_multi.sv
// Directed bench for tank_ctrl_multi (NUM_PUMPS=4, FILTER_CYCLES=4).
module tb_tank_ctrl_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic       I, S;
  logic [3:0] pump_en;
  logic       fault_clr;
  logic [3:0] B;
  logic [1:0] level_state;
  logic [1:0] active_pump;
  logic       fault;
  logic       no_pump;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] ST_FULL = 2'b11, ST_HALF = 2'b01, ST_EMPTY = 2'b00, ST_FAULT = 2'b10;

  tank_ctrl_multi #(.NUM_PUMPS(4), .FILTER_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .I           (I),
    .S           (S),
    .pump_en     (pump_en),
    .fault_clr   (fault_clr),
    .B           (B),
    .level_state (level_state),
    .active_pump (active_pump),
    .fault       (fault),
    .no_pump     (no_pump)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic s);
    I = i;
    S = s;
  endtask

  task automatic test_reset;
    reset = 1'b0; fault_clr = 1'b0; pump_en = 4'b1111;
    drive(1'b1, 1'b1);
    step(2);
    n_chk++; if (level_state !== ST_FULL) $display("FAIL rst_state: got %b exp %b", level_state, ST_FULL); else n_pass++;
    n_chk++; if (B !== 4'b0000) $display("FAIL rst_b: got %b exp %b", B, 4'b0000); else n_pass++;
    n_chk++; if (active_pump !== 2'd3) $display("FAIL rst_ptr: got %0d exp 3", active_pump); else n_pass++;
    n_chk++; if (fault !== 1'b0 || no_pump !== 1'b0) $display("FAIL rst_flags: got fault=%b no_pump=%b exp 0/0", fault, no_pump); else n_pass++;
  endtask

  task automatic test_first_half;
    reset = 1'b1;
    drive(1'b1, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      step(1);
      n_chk++; if (level_state !== ST_FULL || B !== 4'b0000)
        $display("FAIL latency_e%0d: got state=%b B=%b exp state=11 B=0000", e, level_state, B); else n_pass++;
    end
    step(1);
    n_chk++; if (level_state !== ST_HALF) $display("FAIL first_half_state: got %b exp %b", level_state, ST_HALF); else n_pass++;
    n_chk++; if (B !== 4'b0001) $display("FAIL first_half_b: got %b exp 0001", B); else n_pass++;
    n_chk++; if (active_pump !== 2'd0) $display("FAIL first_half_ptr: got %0d exp 0", active_pump); else n_pass++;
  endtask

  task automatic test_rotation;
    logic [3:0] exp_b [4];
    exp_b[0] = 4'b0010; exp_b[1] = 4'b0100; exp_b[2] = 4'b1000; exp_b[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1); step(5);
      n_chk++; if (level_state !== ST_FULL || B !== 4'b0000)
        $display("FAIL rot_full%0d: got state=%b B=%b exp 11/0000", k, level_state, B); else n_pass++;
      drive(1'b1, 1'b0); step(5);
      n_chk++; if (level_state !== ST_HALF || B !== exp_b[k])
        $display("FAIL rot_half%0d: got state=%b B=%b exp 01/%b", k, level_state, B, exp_b[k]); else n_pass++;
    end
  endtask

  task automatic test_mask;
    drive(1'b1, 1'b1); step(5);
    pump_en = 4'b1010;
    drive(1'b1, 1'b0); step(5);
    n_chk++; if (active_pump !== 2'd1 || B !== 4'b0010)
      $display("FAIL mask_skip0: got ptr=%0d B=%b exp 1/0010", active_pump, B); else n_pass++;
    drive(1'b1, 1'b1); step(5);
    drive(1'b1, 1'b0); step(5);
    n_chk++; if (active_pump !== 2'd3 || B !== 4'b1000)
      $display("FAIL mask_skip2: got ptr=%0d B=%b exp 3/1000", active_pump, B); else n_pass++;
    pump_en = 4'b0010;
    step(1);
    n_chk++; if (active_pump !== 2'd1 || B !== 4'b0010)
      $display("FAIL mask_drop: got ptr=%0d B=%b exp 1/0010", active_pump, B); else n_pass++;
  endtask

  task automatic test_glitch;
    drive(1'b1, 1'b1); step(5);
    pump_en = 4'b1011;
    I = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step(1);
      n_chk++; if (level_state !== ST_FULL || B !== 4'b0000)
        $display("FAIL glitch_lo%0d: got state=%b B=%b exp 11/0000", e, level_state, B); else n_pass++;
    end
    I = 1'b1;
    step(4);
    n_chk++; if (level_state !== ST_FULL || B !== 4'b0000)
      $display("FAIL glitch_after: got state=%b B=%b exp 11/0000", level_state, B); else n_pass++;
    drive(1'b0, 1'b0); step(4);
    n_chk++; if (level_state !== ST_FULL) $display("FAIL empty_early: got %b exp 11", level_state); else n_pass++;
    step(1);
    n_chk++; if (level_state !== ST_EMPTY || B !== 4'b1011)
      $display("FAIL empty: got state=%b B=%b exp 00/1011", level_state, B); else n_pass++;
  endtask

  task automatic test_fault;
    drive(1'b0, 1'b1); step(5);
    n_chk++; if (level_state !== ST_FAULT || fault !== 1'b1 || B !== 4'b0000)
      $display("FAIL fault_enter: got state=%b fault=%b B=%b exp 10/1/0000", level_state, fault, B); else n_pass++;
    fault_clr = 1'b1; step(2);
    n_chk++; if (level_state !== ST_FAULT || fault !== 1'b1)
      $display("FAIL fault_clr_bad: got state=%b fault=%b exp 10/1", level_state, fault); else n_pass++;
    fault_clr = 1'b0;
    drive(1'b1, 1'b1); step(6);
    n_chk++; if (level_state !== ST_FAULT || fault !== 1'b1)
      $display("FAIL fault_sticky: got state=%b fault=%b exp 10/1", level_state, fault); else n_pass++;
    fault_clr = 1'b1; step(1);
    fault_clr = 1'b0;
    n_chk++; if (level_state !== ST_FULL || fault !== 1'b0 || B !== 4'b0000)
      $display("FAIL fault_exit: got state=%b fault=%b B=%b exp 11/0/0000", level_state, fault, B); else n_pass++;
  endtask

  task automatic test_no_pump_and_reset;
    drive(1'b0, 1'b0); step(5);
    n_chk++; if (level_state !== ST_EMPTY || B !== 4'b1011)
      $display("FAIL np_empty: got state=%b B=%b exp 00/1011", level_state, B); else n_pass++;
    pump_en = 4'b0000; step(1);
    n_chk++; if (no_pump !== 1'b1 || B !== 4'b0000 || level_state !== ST_EMPTY)
      $display("FAIL no_pump: got np=%b B=%b state=%b exp 1/0000/00", no_pump, B, level_state); else n_pass++;
    pump_en = 4'b1111; step(1);
    n_chk++; if (no_pump !== 1'b0 || B !== 4'b1111)
      $display("FAIL np_restore: got np=%b B=%b exp 0/1111", no_pump, B); else n_pass++;
    drive(1'b1, 1'b0); step(5);
    n_chk++; if (level_state !== ST_HALF || active_pump !== 2'd2 || B !== 4'b0100)
      $display("FAIL pre_rst_half: got state=%b ptr=%0d B=%b exp 01/2/0100", level_state, active_pump, B); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_chk++; if (level_state !== ST_FULL || B !== 4'b0000 || active_pump !== 2'd3 || fault !== 1'b0)
      $display("FAIL async_rst: got state=%b B=%b ptr=%0d fault=%b exp 11/0000/3/0", level_state, B, active_pump, fault); else n_pass++;
    #2 reset = 1'b1;
    step(4);
    n_chk++; if (level_state !== ST_FULL) $display("FAIL rst_refilter: got %b exp 11", level_state); else n_pass++;
    step(1);
    n_chk++; if (level_state !== ST_HALF || active_pump !== 2'd0 || B !== 4'b0001)
      $display("FAIL rst_half: got state=%b ptr=%0d B=%b exp 01/0/0001", level_state, active_pump, B); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_first_half;
    test_rotation;
    test_mask;
    test_glitch;
    test_fault;
    test_no_pump_and_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
